prog_fetch_unit: RTL and testbench

//  Upstream instruction sequencer for the simple 9-bit bus processor. Owns the program

---
 rtl/prog_fetch_unit_if.sv | 32 +++
 rtl/prog_fetch_unit.sv | 134 +++++++++++++
 tb/tb_prog_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_fetch_unit_if.sv
// Bus between the program fetch unit, its instruction ROM and the 9-bit processor.
// The fetch unit is the master: it drives the ROM address, the processor's DIN/Run
// and the status flags. The slave side is the ROM/processor/control environment.
interface prog_fetch_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 9
);
  // Control and processor handshake
  logic              Start;
  logic              Loop;
  logic              Done;
  // Synchronous instruction ROM
  logic [DATA_W-1:0] rom_q;
  logic [ADDR_W-1:0] rom_addr;
  // Processor data path and status
  logic [DATA_W-1:0] DIN;
  logic              Run;
  logic              Busy;
  logic              Halted;
  logic              Error;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  Start, Loop, Done, rom_q,
    output rom_addr, DIN, Run, Busy, Halted, Error, pc
  );

  modport slave (
    output Start, Loop, Done, rom_q,
    input  rom_addr, DIN, Run, Busy, Halted, Error, pc
  );
endinterface

// File: rtl/prog_fetch_unit.sv
// Instruction sequencer for the 9-bit bus processor. Owns the program counter,
// addresses a 1-cycle-latency instruction ROM, issues each word on DIN with a
// single-cycle Run pulse, supplies the mvi immediate and waits for Done before
// moving on. A watchdog flags a processor that never reports Done.
module prog_fetch_unit #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 9,
  parameter int LAST_ADDR = 31,
  parameter int MAX_EXEC  = 8
) (
  input  logic               Clock,
  input  logic               Resetn,
  prog_fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_EXEC  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(LAST_ADDR);
  localparam logic [3:0]        WD_LIMIT = 4'(MAX_EXEC - 1);
  localparam logic [2:0]        OP_MVI   = 3'b001;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [3:0]        wd_q, wd_d;
  logic              is_mvi_q, is_mvi_d;
  logic              halted_q, halted_d;
  logic              error_q, error_d;

  // Address arithmetic wraps naturally modulo 2**ADDR_W.
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_plus2;
  logic [ADDR_W-1:0] pc_step;
  logic              end_reached;

  assign pc_plus1    = pc_q + ADDR_W'(1);
  assign pc_plus2    = pc_q + ADDR_W'(2);
  assign pc_step     = is_mvi_q ? pc_plus2 : pc_plus1;
  assign end_reached = (pc_q == LAST) || (is_mvi_q && (pc_plus1 == LAST));

  // State and datapath registers; every one is reset so a mid-instruction reset is clean.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      rom_addr_q <= '0;
      wd_q       <= '0;
      is_mvi_q   <= 1'b0;
      halted_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      rom_addr_q <= rom_addr_d;
      wd_q       <= wd_d;
      is_mvi_q   <= is_mvi_d;
      halted_q   <= halted_d;
      error_q    <= error_d;
    end
  end

  // Next-state and next-register logic for the fetch/issue/execute sequence.
  always_comb begin
    // NOTE: hold-value defaults first, so no path through the case can infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    rom_addr_d = rom_addr_q;
    wd_d       = wd_q;
    is_mvi_d   = is_mvi_q;
    halted_d   = halted_q;
    error_d    = error_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d    = S_FETCH;
          halted_d   = 1'b0;
          error_d    = 1'b0;
          rom_addr_d = pc_q;
        end
      end

      S_FETCH: begin
        // The ROM captures pc during FETCH, so the instruction appears in ISSUE.
        // Presenting pc+1 during ISSUE makes the following word (the mvi
        // immediate) valid on rom_q from the first EXEC cycle onward.
        state_d    = S_ISSUE;
        rom_addr_d = pc_plus1;
      end

      S_ISSUE: begin
        state_d  = S_EXEC;
        is_mvi_d = (bus.rom_q[DATA_W-1 -: 3] == OP_MVI);
        wd_d     = '0;
      end

      S_EXEC: begin
        // Done takes priority over a watchdog expiry in the same cycle.
        if (bus.Done) begin
          if (!bus.Loop && end_reached) begin
            halted_d = 1'b1;
            pc_d     = '0;
            state_d  = S_IDLE;
          end else begin
            pc_d       = pc_step;
            rom_addr_d = pc_step;
            state_d    = S_FETCH;
          end
        end else if (wd_q == WD_LIMIT) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 4'd1;
        end
      end
    endcase
  end

  // Processor-facing outputs decode straight from state so reset clears them at once.
  assign bus.Run      = (state_q == S_ISSUE);
  assign bus.Busy     = (state_q != S_IDLE);
  assign bus.DIN      = ((state_q == S_ISSUE) || (state_q == S_EXEC)) ? bus.rom_q : '0;
  assign bus.rom_addr = rom_addr_q;
  assign bus.pc       = pc_q;
  assign bus.Halted   = halted_q;
  assign bus.Error    = error_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit: a behavioural 1-cycle ROM plus hand-driven
// Done pulses; inputs change and outputs are sampled on the falling clock edge.
module tb_prog_fetch_unit;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 9;

  localparam logic [DATA_W-1:0] MV_R1_R0  = 9'o010;
  localparam logic [DATA_W-1:0] MVI_R2    = 9'o120;
  localparam logic [DATA_W-1:0] IMM_77    = 9'd77;

  logic Clock;
  logic Resetn;

  prog_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  prog_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LAST_ADDR(31),
    .MAX_EXEC (8)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  logic [DATA_W-1:0] rom [32];

  int n_tests = 0;
  int n_fail  = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Synchronous ROM: data reflects the address presented in the previous cycle.
  always @(posedge Clock) bus.rom_q <= rom[bus.rom_addr];

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish within 200000 time units");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance falling edges until Run is seen, with a cycle budget.
  task automatic wait_run(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!bus.Run && n < 16);
    check({tag, " run"}, 32'(bus.Run), 32'd1);
  endtask

  // Let one instruction complete with Done in its first EXEC cycle.
  task automatic step_instr(input string tag);
    wait_run(tag);
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
  endtask

  initial begin
    int g;
    for (int k = 0; k < 32; k++) rom[k] = MV_R1_R0;
    rom[3] = MVI_R2;
    rom[4] = IMM_77;

    Resetn    = 1'b0;
    bus.Start = 1'b0;
    bus.Loop  = 1'b0;
    bus.Done  = 1'b0;
    repeat (2) @(negedge Clock);

    // Reset state
    check("rst run",      32'(bus.Run),      32'd0);
    check("rst busy",     32'(bus.Busy),     32'd0);
    check("rst pc",       32'(bus.pc),       32'd0);
    check("rst rom_addr", 32'(bus.rom_addr), 32'd0);
    check("rst halted",   32'(bus.Halted),   32'd0);
    check("rst error",    32'(bus.Error),    32'd0);
    check("rst din",      32'(bus.DIN),      32'd0);

    // Test 1: Start, mv sequence, Run every 3 cycles
    Resetn    = 1'b1;
    bus.Loop  = 1'b1;
    bus.Start = 1'b1;
    @(negedge Clock);                               // cycle 1: FETCH
    check("t1 fetch busy", 32'(bus.Busy), 32'd1);
    check("t1 fetch run",  32'(bus.Run),  32'd0);
    bus.Start = 1'b0;
    @(negedge Clock);                               // cycle 2: ISSUE
    check("t1 run c2",   32'(bus.Run), 32'd1);
    check("t1 din c2",   32'(bus.DIN), 32'(MV_R1_R0));
    check("t1 pc c2",    32'(bus.pc),  32'd0);
    @(negedge Clock);                               // cycle 3: EXEC
    check("t1 run pulse", 32'(bus.Run), 32'd0);
    bus.Done = 1'b1;
    @(negedge Clock);                               // cycle 4: FETCH
    bus.Done = 1'b0;
    check("t1 pc 1",     32'(bus.pc),  32'd1);
    @(negedge Clock);                               // cycle 5
    check("t1 run c5",   32'(bus.Run), 32'd1);
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t1 pc 2",     32'(bus.pc),  32'd2);
    @(negedge Clock);                               // cycle 8
    check("t1 run c8",   32'(bus.Run), 32'd1);

    // Test 2: mvi at 3 with immediate 77 at 4
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t2 pc 3",     32'(bus.pc),  32'd3);
    @(negedge Clock);                               // ISSUE mvi
    check("t2 run",      32'(bus.Run), 32'd1);
    check("t2 din ir",   32'(bus.DIN), 32'(MVI_R2));
    @(negedge Clock);                               // first EXEC cycle
    check("t2 din imm",  32'(bus.DIN), 32'd77);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t2 pc 5",       32'(bus.pc),       32'd5);
    check("t2 rom_addr 5", 32'(bus.rom_addr), 32'd5);

    // Test 3: Loop=1 wrap from 31 to 0
    g = 0;
    while (bus.pc != 5'd31 && g < 40) begin
      step_instr("t3 step");
      g++;
    end
    check("t3 pc 31", 32'(bus.pc), 32'd31);
    wait_run("t3 at 31");
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t3 pc wrap",       32'(bus.pc),       32'd0);
    check("t3 rom_addr wrap", 32'(bus.rom_addr), 32'd0);
    check("t3 busy",          32'(bus.Busy),     32'd1);
    check("t3 fetch run",     32'(bus.Run),      32'd0);
    check("t3 halted",        32'(bus.Halted),   32'd0);
    @(negedge Clock);
    check("t3 issue after wrap", 32'(bus.Run), 32'd1);
    check("t3 din word0",        32'(bus.DIN), 32'(MV_R1_R0));
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t3 pc 1", 32'(bus.pc), 32'd1);

    // Test 5: watchdog expiry at pc 1
    wait_run("t5");
    for (int i = 0; i < 8; i++) @(negedge Clock);   // EXEC cycles 1..8
    check("t5 no error yet", 32'(bus.Error), 32'd0);
    check("t5 busy in exec", 32'(bus.Busy),  32'd1);
    @(negedge Clock);
    check("t5 error",      32'(bus.Error), 32'd1);
    check("t5 idle busy",  32'(bus.Busy),  32'd0);
    check("t5 run",        32'(bus.Run),   32'd0);
    check("t5 pc kept",    32'(bus.pc),    32'd1);

    // Done coinciding with the last watchdog cycle wins
    bus.Start = 1'b1;
    @(negedge Clock);
    check("t5b error clr", 32'(bus.Error), 32'd0);
    check("t5b busy",      32'(bus.Busy),  32'd1);
    bus.Start = 1'b0;
    wait_run("t5b");
    for (int i = 0; i < 7; i++) @(negedge Clock);   // EXEC cycles 1..7
    @(negedge Clock);                               // EXEC cycle 8
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t5b no error", 32'(bus.Error), 32'd0);
    check("t5b pc 2",     32'(bus.pc),    32'd2);
    check("t5b busy",     32'(bus.Busy),  32'd1);

    // Test 4: Loop=0 halts after the last word
    bus.Loop = 1'b0;
    g = 0;
    while (bus.pc != 5'd31 && g < 40) begin
      step_instr("t4 step");
      g++;
    end
    check("t4 pc 31", 32'(bus.pc), 32'd31);
    wait_run("t4 at 31");
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    check("t4 halted", 32'(bus.Halted), 32'd1);
    check("t4 busy",   32'(bus.Busy),   32'd0);
    check("t4 pc 0",   32'(bus.pc),     32'd0);
    check("t4 run",    32'(bus.Run),    32'd0);
    // Done while idle is ignored
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    @(negedge Clock);
    check("t4 idle done busy",   32'(bus.Busy),   32'd0);
    check("t4 idle done halted", 32'(bus.Halted), 32'd1);
    bus.Start = 1'b1;
    @(negedge Clock);
    check("t4 restart halted", 32'(bus.Halted), 32'd0);
    check("t4 restart busy",   32'(bus.Busy),   32'd1);
    bus.Start = 1'b0;
    @(negedge Clock);
    check("t4 restart run", 32'(bus.Run), 32'd1);
    check("t4 restart pc",  32'(bus.pc),  32'd0);

    // Test 6: asynchronous reset during EXEC
    @(negedge Clock);
    bus.Done = 1'b1;
    @(negedge Clock);
    bus.Done = 1'b0;
    wait_run("t6");
    @(negedge Clock);                               // EXEC of pc 1
    check("t6 exec rom_addr", 32'(bus.rom_addr), 32'd2);
    check("t6 exec pc",       32'(bus.pc),       32'd1);
    #2;
    Resetn = 1'b0;
    #1;
    check("t6 rst run",      32'(bus.Run),      32'd0);
    check("t6 rst busy",     32'(bus.Busy),     32'd0);
    check("t6 rst pc",       32'(bus.pc),       32'd0);
    check("t6 rst rom_addr", 32'(bus.rom_addr), 32'd0);
    check("t6 rst din",      32'(bus.DIN),      32'd0);
    @(negedge Clock);
    Resetn    = 1'b1;
    bus.Start = 1'b1;
    @(negedge Clock);
    check("t6 refetch addr", 32'(bus.rom_addr), 32'd0);
    check("t6 refetch busy", 32'(bus.Busy),     32'd1);
    bus.Start = 1'b0;
    @(negedge Clock);
    check("t6 reissue run", 32'(bus.Run), 32'd1);
    check("t6 reissue din", 32'(bus.DIN), 32'(MV_R1_R0));
    check("t6 reissue pc",  32'(bus.pc),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
